led_band_scan_sequencer: RTL and testbench

Timing master for one LED band. It generates SCLK, LAT and the angle/row/color/bit_sel scan indices that led_band_controller consumes to serialize grey-scale data into the LED driver chain. One full shift-and-latch scan runs per angular position tick. The block tracks the current angle from rotation-sensor ticks and flags scans that overrun the next tick.

---
 rtl/led_band_scan_sequencer_if.sv | 57 +++++
 rtl/led_band_scan_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_led_band_scan_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_band_scan_sequencer_if.sv
// led_band_scan_sequencer_if
// Control inputs and scan-timing outputs of the LED band scan sequencer.
// The sequencer connects through the master modport. The consumer or stimulus
// side connects through the slave modport.
// Optional macro SCAN_FREERUN_EN adds the free_run control input.
`timescale 1ns/1ps
interface led_band_scan_sequencer_if #(
  parameter int NB_LED_COLUMN = 32,
  parameter int BIT_PER_COLOR = 8,
  parameter int NB_0_LSB      = 1,
  parameter int NB_ANGLES     = 128
);
  localparam int NB_BITS = BIT_PER_COLOR + NB_0_LSB;
  localparam int AW      = (NB_ANGLES > 1) ? $clog2(NB_ANGLES) : 1;
  localparam int RW      = (NB_LED_COLUMN > 1) ? $clog2(NB_LED_COLUMN) : 1;
  localparam int BW      = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

  // Control inputs
  logic          enable;
  logic          angle_tick;
  logic          index_tick;
  logic          overrun_clr;
`ifdef SCAN_FREERUN_EN
  logic          free_run;
`endif

  // Scan timing and index outputs
  logic          SCLK;
  logic          LAT;
  logic [AW-1:0] angle;
  logic [RW-1:0] row;
  logic [1:0]    color;
  logic [BW-1:0] bit_sel;
  logic          busy;
  logic          scan_done;
  logic          overrun;

`ifdef SCAN_FREERUN_EN
  modport master (
    input  enable, angle_tick, index_tick, overrun_clr, free_run,
    output SCLK, LAT, angle, row, color, bit_sel, busy, scan_done, overrun
  );
  modport slave (
    output enable, angle_tick, index_tick, overrun_clr, free_run,
    input  SCLK, LAT, angle, row, color, bit_sel, busy, scan_done, overrun
  );
`else
  modport master (
    input  enable, angle_tick, index_tick, overrun_clr,
    output SCLK, LAT, angle, row, color, bit_sel, busy, scan_done, overrun
  );
  modport slave (
    output enable, angle_tick, index_tick, overrun_clr,
    input  SCLK, LAT, angle, row, color, bit_sel, busy, scan_done, overrun
  );
`endif
endinterface

// File: rtl/led_band_scan_sequencer.sv
// led_band_scan_sequencer
// This is the timing master for one LED band. It tracks the rotor angle from
// sensor ticks. It runs one shift-and-latch scan per accepted angle tick, which
// produces SCLK, LAT and the row/color/bit_sel indices for the band controller.
// A tick that arrives while a scan is still running sets a sticky overrun flag.
// Optional macro SCAN_FREERUN_EN: adds free_run. When free_run is set, scans
// repeat back to back at a constant angle.
`timescale 1ns/1ps
module led_band_scan_sequencer #(
  parameter int NB_LED_COLUMN = 32,
  parameter int BIT_PER_COLOR = 8,
  parameter int NB_0_LSB      = 1,
  parameter int NB_ANGLES     = 128,
  parameter int SCLK_HALF     = 4,
  parameter int LAT_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  led_band_scan_sequencer_if.master bus
);
  localparam int NB_BITS = BIT_PER_COLOR + NB_0_LSB;
  localparam int AW      = (NB_ANGLES > 1) ? $clog2(NB_ANGLES) : 1;
  localparam int RW      = (NB_LED_COLUMN > 1) ? $clog2(NB_LED_COLUMN) : 1;
  localparam int BW      = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;
  // One counter times both the bit period and the latch pulse.
  localparam int CYC_MAX = (2 * SCLK_HALF > LAT_CYCLES) ? 2 * SCLK_HALF : LAT_CYCLES;
  localparam int CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [AW-1:0] ANGLE_LAST = AW'(NB_ANGLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(NB_LED_COLUMN - 1);
  localparam logic [BW-1:0] BMAX       = BW'(NB_BITS - 1);
  localparam logic [1:0]    COLOR_LAST = 2'd2;
  localparam logic [CW-1:0] BIT_LAST   = CW'(2 * SCLK_HALF - 1);
  localparam logic [CW-1:0] HIGH_FIRST = CW'(SCLK_HALF);
  localparam logic [CW-1:0] LAT_LAST   = CW'(LAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    color_q, color_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [AW-1:0] angle_q, angle_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          sclk_q, sclk_d;
  logic          lat_q, lat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic          fr_s;
  logic          start_s;
  logic          restart_s;
  logic          last_bit_s;
  logic          ovr_set_s;

`ifdef SCAN_FREERUN_EN
  assign fr_s = bus.free_run;
`else
  assign fr_s = 1'b0;
`endif

  // A scan can start only from IDLE, on an angle tick, while enabled.
  assign start_s    = (state_q == ST_IDLE) && bus.angle_tick && bus.enable;
  // A back-to-back restart at the end of the latch phase is possible only in free-run mode.
  assign restart_s  = fr_s && bus.enable;
  assign last_bit_s = (row_q == ROW_LAST) && (color_q == COLOR_LAST) && (bit_q == '0);
  // A tick that arrives during a scan is dropped and reported, except in free-run mode.
  assign ovr_set_s  = bus.angle_tick && (state_q != ST_IDLE) && !fr_s;

  // Angle counter: index_tick forces 0 and has priority over angle_tick, which increments with wrap.
  always_comb begin
    acnt_d = acnt_q;
    if (bus.index_tick) begin
      acnt_d = '0;
    end else if (bus.angle_tick) begin
      if (acnt_q == ANGLE_LAST) begin
        acnt_d = '0;
      end else begin
        acnt_d = acnt_q + AW'(1);
      end
    end else begin
      acnt_d = acnt_q;
    end
  end

  // Scan FSM: state, the bit/latch cycle counter, the scan indices and the scan_done pulse.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    row_d   = row_q;
    color_d = color_q;
    bit_d   = bit_q;
    angle_d = angle_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (start_s) begin
          state_d = ST_SHIFT;
          row_d   = '0;
          color_d = 2'd0;
          bit_d   = BMAX;
          // The counter value after this tick is the angle used for the whole scan.
          angle_d = acnt_d;
        end else begin
          row_d   = '0;
          color_d = 2'd0;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (last_bit_s) begin
            state_d = ST_LATCH;
          end else if (bit_q == '0) begin
            bit_d = BMAX;
            if (color_q == COLOR_LAST) begin
              color_d = 2'd0;
              row_d   = row_q + RW'(1);
            end else begin
              color_d = color_q + 2'd1;
            end
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_LATCH: begin
        if (cyc_q == LAT_LAST) begin
          cyc_d  = '0;
          done_d = 1'b1;
          if (restart_s) begin
            state_d = ST_SHIFT;
            row_d   = '0;
            color_d = 2'd0;
            bit_d   = BMAX;
          end else begin
            state_d = ST_IDLE;
            row_d   = '0;
            color_d = 2'd0;
            bit_d   = '0;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        row_d   = '0;
        color_d = 2'd0;
        bit_d   = '0;
      end
    endcase
  end

  // Output waveform decode. It uses the next state, so SCLK/LAT/busy are registered and aligned with the indices.
  always_comb begin
    sclk_d = 1'b0;
    lat_d  = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (cyc_d >= HIGH_FIRST) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
        end
      end
      ST_LATCH: begin
        busy_d = 1'b1;
        lat_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Sticky overrun flag. A set takes priority over a clear in the same cycle.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (bus.overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers. Reset aborts any scan at once, with no latch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      row_q   <= '0;
      color_q <= 2'd0;
      bit_q   <= '0;
      angle_q <= '0;
      acnt_q  <= '0;
      sclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      row_q   <= row_d;
      color_q <= color_d;
      bit_q   <= bit_d;
      angle_q <= angle_d;
      acnt_q  <= acnt_d;
      sclk_q  <= sclk_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.SCLK      = sclk_q;
  assign bus.LAT       = lat_q;
  assign bus.angle     = angle_q;
  assign bus.row       = row_q;
  assign bus.color     = color_q;
  assign bus.bit_sel   = bit_q;
  assign bus.busy      = busy_q;
  assign bus.scan_done = done_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_led_band_scan_sequencer.sv
// tb_led_band_scan_sequencer
// Self-checking bench for led_band_scan_sequencer using a small configuration.
// The expected waveform is computed arithmetically from the cycle offset within a scan.
// Define SCAN_FREERUN_EN to include the free-run scenario.
`timescale 1ns/1ps
module tb_led_band_scan_sequencer;
  localparam int NL   = 2;
  localparam int NBPC = 2;
  localparam int NZ   = 1;
  localparam int NA   = 4;
  localparam int SH   = 2;
  localparam int LC   = 3;
  localparam int NBIT       = NBPC + NZ;
  localparam int TOTAL_BITS = NL * 3 * NBIT;
  localparam int SHIFT_LEN  = TOTAL_BITS * 2 * SH;
  localparam int SCAN_LEN   = SHIFT_LEN + LC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   acnt_m = 0;
  int   last_ang = 0;

  always #5 clk = ~clk;

  led_band_scan_sequencer_if #(
    .NB_LED_COLUMN(NL), .BIT_PER_COLOR(NBPC), .NB_0_LSB(NZ), .NB_ANGLES(NA)
  ) bus ();

  led_band_scan_sequencer #(
    .NB_LED_COLUMN(NL), .BIT_PER_COLOR(NBPC), .NB_0_LSB(NZ), .NB_ANGLES(NA),
    .SCLK_HALF(SH), .LAT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Observed vector: {busy, SCLK, LAT, scan_done, row, color, bit_sel, angle}
  logic [10:0] obs_vec;
  assign obs_vec = {bus.busy, bus.SCLK, bus.LAT, bus.scan_done,
                    bus.row, bus.color, bus.bit_sel, bus.angle};

  // Reference model. k is the number of cycles since the first cycle after the start tick.
  function automatic logic [10:0] exp_vec(int k, int ang, bit fr);
    int kk, n, r, c, bs;
    logic b, s, l, d;
    kk = k; d = 1'b0; b = 1'b0; s = 1'b0; l = 1'b0; r = 0; c = 0; bs = 0;
    if (fr && k >= SCAN_LEN) begin
      kk = k % SCAN_LEN;
      d  = (kk == 0);
    end
    if (kk < SHIFT_LEN) begin
      n  = kk / (2 * SH);
      b  = 1'b1;
      s  = ((kk % (2 * SH)) >= SH);
      r  = n / (3 * NBIT);
      c  = (n / NBIT) % 3;
      bs = NBIT - 1 - (n % NBIT);
    end else if (kk < SCAN_LEN) begin
      b  = 1'b1;
      l  = 1'b1;
      r  = NL - 1;
      c  = 2;
      bs = 0;
    end else begin
      d = (kk == SCAN_LEN);
    end
    return {b, s, l, d, 1'(r), 2'(c), 2'(bs), 2'(ang)};
  endfunction

  function automatic int adv(int a, bit idx);
    return idx ? 0 : (a + 1) % NA;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.angle_tick = 1'b0; bus.index_tick = 1'b0; bus.overrun_clr = 1'b0;
`ifdef SCAN_FREERUN_EN
    bus.free_run = 1'b0;
`endif
    rst = 1'b1;
    step(); step();
    tests++;
    if (obs_vec !== 11'd0) begin
      fails++; $display("FAIL reset_hold: got %b want %b", obs_vec, 11'd0);
    end
    rst = 1'b0;
    step();
    tests++;
    if (obs_vec !== 11'd0 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL reset_release: got %b/%b want %b/0", obs_vec, bus.overrun, 11'd0);
    end
    acnt_m = 0; last_ang = 0;
  endtask

  task automatic test_basic_scan();
    int ang, rises, lat_n;
    logic prev;
    logic [10:0] e;
    rises = 0; lat_n = 0; prev = 1'b0;
    bus.enable = 1'b1; bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k <= SCAN_LEN + 3; k++) begin
      e = exp_vec(k, ang, 1'b0);
      tests++;
      if (obs_vec !== e) begin
        fails++; $display("FAIL basic_scan k=%0d: got %b want %b", k, obs_vec, e);
      end
      if (bus.SCLK === 1'b1 && prev === 1'b0) rises++;
      prev = bus.SCLK;
      if (bus.LAT === 1'b1) lat_n++;
      step();
    end
    tests++;
    if (rises != TOTAL_BITS) begin
      fails++; $display("FAIL basic_sclk_pulses: got %0d want %0d", rises, TOTAL_BITS);
    end
    tests++;
    if (lat_n != LC) begin
      fails++; $display("FAIL basic_lat_cycles: got %0d want %0d", lat_n, LC);
    end
    tests++;
    if (bus.overrun !== 1'b0) begin
      fails++; $display("FAIL basic_no_overrun: got %b want 0", bus.overrun);
    end
    last_ang = ang;
  endtask

  task automatic test_angle_wrap();
    int ang;
    logic [10:0] e;
    for (int s = 0; s < 5; s++) begin
      // Wait a random number of idle cycles between scans.
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) step();
      bus.angle_tick = 1'b1; bus.index_tick = (s == 4);
      acnt_m = adv(acnt_m, s == 4); ang = acnt_m;
      step(); bus.angle_tick = 1'b0; bus.index_tick = 1'b0;
      for (int k = 0; k <= SCAN_LEN; k++) begin
        e = exp_vec(k, ang, 1'b0);
        tests++;
        if (obs_vec !== e) begin
          fails++; $display("FAIL angle_wrap s=%0d k=%0d: got %b want %b", s, k, obs_vec, e);
        end
        step();
      end
      last_ang = ang;
    end
  endtask

  task automatic test_overrun();
    int ang;
    logic [10:0] e;
    for (int s = 0; s < 2; s++) begin
      bus.angle_tick = 1'b1;
      acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
      step(); bus.angle_tick = 1'b0;
      for (int k = 0; k <= SCAN_LEN + 10; k++) begin
        e = exp_vec(k, ang, 1'b0);
        tests++;
        if (obs_vec !== e) begin
          fails++; $display("FAIL overrun_scan s=%0d k=%0d: got %b want %b", s, k, obs_vec, e);
        end
        if (k == (s == 0 ? 20 : 10)) begin
          tests++;
          if (bus.overrun !== 1'b0) begin
            fails++; $display("FAIL overrun_pre s=%0d: got %b want 0", s, bus.overrun);
          end
          bus.angle_tick = 1'b1; bus.overrun_clr = (s == 1);
          acnt_m = adv(acnt_m, 1'b0);
        end
        step();
        bus.angle_tick = 1'b0; bus.overrun_clr = 1'b0;
      end
      tests++;
      if (bus.overrun !== 1'b1) begin
        fails++; $display("FAIL overrun_sticky s=%0d: got %b want 1", s, bus.overrun);
      end
      bus.overrun_clr = 1'b1;
      step(); bus.overrun_clr = 1'b0;
      tests++;
      if (bus.overrun !== 1'b0) begin
        fails++; $display("FAIL overrun_clear s=%0d: got %b want 0", s, bus.overrun);
      end
      last_ang = ang;
    end
  endtask

  task automatic test_gate();
    int ang;
    logic [10:0] e;
    bus.enable = 1'b0; bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0);
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k < 20; k++) begin
      e = exp_vec(SCAN_LEN + 1, last_ang, 1'b0);
      tests++;
      if (obs_vec !== e) begin
        fails++; $display("FAIL gate_idle k=%0d: got %b want %b", k, obs_vec, e);
      end
      step();
    end
    bus.enable = 1'b1; bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k <= SCAN_LEN; k++) begin
      e = exp_vec(k, ang, 1'b0);
      tests++;
      if (obs_vec !== e) begin
        fails++; $display("FAIL gate_reenabled k=%0d: got %b want %b", k, obs_vec, e);
      end
      step();
    end
    last_ang = ang;
  endtask

  task automatic test_reset_midscan();
    int ang;
    logic [10:0] e;
    bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      e = exp_vec(k, ang, 1'b0);
      tests++;
      if (obs_vec !== e) begin
        fails++; $display("FAIL midscan_pre k=%0d: got %b want %b", k, obs_vec, e);
      end
      if (k == 5) bus.angle_tick = 1'b1;
      if (k == 30) rst = 1'b1;
      step();
      bus.angle_tick = 1'b0;
    end
    rst = 1'b0;
    acnt_m = 0;
    for (int k = 0; k < 60; k++) begin
      tests++;
      if (obs_vec !== 11'd0 || bus.overrun !== 1'b0) begin
        fails++; $display("FAIL midscan_after_reset k=%0d: got %b/%b want %b/0", k, obs_vec, bus.overrun, 11'd0);
      end
      step();
    end
    bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k <= SCAN_LEN; k++) begin
      e = exp_vec(k, ang, 1'b0);
      tests++;
      if (obs_vec !== e) begin
        fails++; $display("FAIL midscan_restart k=%0d: got %b want %b", k, obs_vec, e);
      end
      step();
    end
    last_ang = ang;
  endtask

`ifdef SCAN_FREERUN_EN
  task automatic test_freerun();
    int ang;
    logic [10:0] e;
    bus.free_run = 1'b1; bus.enable = 1'b1; bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k <= 3 * SCAN_LEN + 2; k++) begin
      e = (k <= 2 * SCAN_LEN) ? exp_vec(k, ang, 1'b1) : exp_vec(k - 2 * SCAN_LEN, ang, 1'b0);
      tests++;
      if (obs_vec !== e || bus.overrun !== 1'b0) begin
        fails++; $display("FAIL freerun k=%0d: got %b/%b want %b/0", k, obs_vec, bus.overrun, e);
      end
      if (k == 100) begin
        bus.angle_tick = 1'b1;
        acnt_m = adv(acnt_m, 1'b0);
      end
      if (k == 200) bus.free_run = 1'b0;
      step();
      bus.angle_tick = 1'b0;
    end
    bus.angle_tick = 1'b1;
    acnt_m = adv(acnt_m, 1'b0); ang = acnt_m;
    step(); bus.angle_tick = 1'b0;
    for (int k = 0; k <= SCAN_LEN; k++) begin
      e = exp_vec(k, ang, 1'b0);
      tests++;
      if (obs_vec !== e) begin
        fails++; $display("FAIL freerun_exit k=%0d: got %b want %b", k, obs_vec, e);
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_angle_wrap();
    test_overrun();
    test_gate();
    test_reset_midscan();
`ifdef SCAN_FREERUN_EN
    test_freerun();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
